// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: FSM state encoding and architectural constants.
// FAULT exists only when FETCH_MISALIGN_TRAP_EN is defined.
package riscv_pkg;

    localparam logic [31:0]  INSN_EBREAK = 32'h00100073;
    localparam int unsigned  PC_STEP     = 4;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        HALTED
`ifdef FETCH_MISALIGN_TRAP_EN
        , FAULT
`endif
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage. Owns the PC, drives the word address of the
// instruction memory, registers each returned instruction with its PC and hands
// it to decode over a valid/ready handshake. Handles redirects and halts on ebreak.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   imem_addr            word index (pc >> 2) to instruction_memory
//   imem_instruction     combinational read data for imem_addr
//   redirect_valid/_pc   load a new byte-address PC this cycle
//   out_valid/out_ready  handshake towards decode
//   out_instr, out_pc    fetched instruction and its byte address
//   halted               fetch stopped after ebreak
//   fault                misaligned redirect trapped (FETCH_MISALIGN_TRAP_EN only)
//
// Build option: define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect targets
// instead of silently forcing them to word alignment.
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter int unsigned          WORDSIZE         = 64,
    parameter int unsigned          INSTRUCTION_SIZE = 32,
    parameter logic [WORDSIZE-1:0]  RESET_PC         = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    output logic [WORDSIZE-1:0]         imem_addr,
    input  logic [INSTRUCTION_SIZE-1:0] imem_instruction,
    input  logic                        redirect_valid,
    input  logic [WORDSIZE-1:0]         redirect_pc,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [INSTRUCTION_SIZE-1:0] out_instr,
    output logic [WORDSIZE-1:0]         out_pc,
    output logic                        halted
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic                        fault
`endif
);

    fetch_state_e                  state_q, state_d;
    logic [WORDSIZE-1:0]           pc_q, pc_d;
    logic                          out_valid_q, out_valid_d;
    logic [INSTRUCTION_SIZE-1:0]   out_instr_q, out_instr_d;
    logic [WORDSIZE-1:0]           out_pc_q, out_pc_d;
    logic                          halted_q, halted_d;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic                          fault_q, fault_d;
`endif

    logic is_ebreak;
    assign is_ebreak = (imem_instruction == INSTRUCTION_SIZE'(INSN_EBREAK));

    // Next-state logic: redirect wins over everything, then per-state behaviour.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;

        if (redirect_valid) begin
            // Any pending output is flushed; one consumed this cycle was already taken.
            out_valid_d = 1'b0;
            out_instr_d = '0;
            out_pc_d    = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            pc_d        = redirect_pc;
            state_d     = (redirect_pc[1:0] != 2'b00) ? FAULT : FETCH;
`else
            pc_d        = redirect_pc & ~WORDSIZE'(3);
            state_d     = FETCH;
`endif
        end else begin
            case (state_q)
                BOOT: begin
                    state_d = FETCH;
                end
                FETCH: begin
                    if (!out_valid_q || out_ready) begin
                        out_valid_d = 1'b1;
                        out_instr_d = imem_instruction;
                        out_pc_d    = pc_q;
                        // PC parks on the ebreak so a later redirect is the only way on.
                        if (is_ebreak) begin
                            state_d = HALTED;
                        end else begin
                            pc_d = pc_q + WORDSIZE'(PC_STEP);
                        end
                    end
                end
                HALTED: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_d = 1'b0;
                    end
                end
`ifdef FETCH_MISALIGN_TRAP_EN
                FAULT: begin
                    out_valid_d = 1'b0;
                end
`endif
                default: begin
                    state_d = BOOT;
                end
            endcase
        end

        halted_d = (state_d == HALTED);
`ifdef FETCH_MISALIGN_TRAP_EN
        fault_d  = (state_d == FAULT);
`endif
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
            halted_q    <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            halted_q    <= halted_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q     <= fault_d;
`endif
        end
    end

    assign imem_addr = {2'b00, pc_q[WORDSIZE-1:2]};
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_pc    = out_pc_q;
    assign halted    = halted_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign fault     = fault_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed phases plus a randomized phase, with a
// scoreboard of expected (pc, instr) transfers consumed by an independent monitor.
module tb_instruction_fetch;
    import riscv_pkg::*;

    localparam int unsigned W         = 64;
    localparam int unsigned IW        = 32;
    localparam int unsigned MEM_WORDS = 256;
    localparam int unsigned SEQ_LEN   = 128;

    typedef struct packed {
        int unsigned   ep;
        logic [W-1:0]  pc;
        logic [IW-1:0] ins;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  imem_addr;
    logic [IW-1:0] imem_instruction;
    logic          redirect_valid = 1'b0;
    logic [W-1:0]  redirect_pc = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [IW-1:0] out_instr;
    logic [W-1:0]  out_pc;
    logic          halted;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic          fault;
`endif

    logic [IW-1:0] mem [MEM_WORDS];
    assign imem_instruction = mem[imem_addr[7:0]];

    instruction_fetch #(.WORDSIZE(W), .INSTRUCTION_SIZE(IW), .RESET_PC('0)) dut (
        .clk              (clk),
        .reset            (reset),
        .imem_addr        (imem_addr),
        .imem_instruction (imem_instruction),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_instr        (out_instr),
        .out_pc           (out_pc),
        .halted           (halted)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fault            (fault)
`endif
    );

    initial forever #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          accepted = 0;
    int unsigned drv_ep = 0;
    int unsigned mon_ep = 0;
    exp_t        sbq[$];

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [IW-1:0] word_at(input logic [W-1:0] p);
        return mem[p[9:2]];
    endfunction

    function automatic logic [IW-1:0] rand_word();
        logic [IW-1:0] w;
        w = $urandom;
        if (w == INSN_EBREAK) w = w ^ 32'h1;
        return w;
    endfunction

    // Program-order model: from a start address, the instructions decode should
    // receive in order, ending at the first ebreak.
    task automatic push_seq(input logic [W-1:0] start);
        logic [W-1:0] p;
        p = start;
        for (int i = 0; i < int'(SEQ_LEN); i++) begin
            sbq.push_back('{ep: drv_ep, pc: p, ins: word_at(p)});
            if (word_at(p) == INSN_EBREAK) break;
            p = p + 64'd4;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Issue a one-cycle redirect; caller drops redirect_valid after the next step.
    task automatic do_redirect(input logic [W-1:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        drv_ep++;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (target[1:0] == 2'b00) push_seq(target);
`else
        push_seq(target & ~64'd3);
`endif
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        drv_ep++;
        for (int i = 0; i < 3; i++) begin
            step();
            sample();
            check("rst_valid", W'(out_valid), '0);
            check("rst_instr", W'(out_instr), '0);
            check("rst_pc", out_pc, '0);
            check("rst_halted", W'(halted), '0);
            check("rst_imem_addr", imem_addr, '0);
`ifdef FETCH_MISALIGN_TRAP_EN
            check("rst_fault", W'(fault), '0);
`endif
        end
        step();
        reset = 1'b0;
        push_seq('0);
    endtask

    // Monitor: checks every transfer against the scoreboard and stall stability.
    initial begin : monitor
        logic          prev_hold;
        logic          rst_prev;
        logic [W-1:0]  prev_pc;
        logic [IW-1:0] prev_ins;
        exp_t          e;
        prev_hold = 1'b0;
        rst_prev  = 1'b0;
        prev_pc   = '0;
        prev_ins  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (!rst_prev) mon_ep++;
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("stall_valid", W'(out_valid), W'(1'b1));
                    check("stall_pc", out_pc, prev_pc);
                    check("stall_instr", W'(out_instr), W'(prev_ins));
                end
                if (out_valid && out_ready) begin
                    while (sbq.size() > 0 && sbq[0].ep < mon_ep) void'(sbq.pop_front());
                    if (sbq.size() == 0 || sbq[0].ep != mon_ep) begin
                        total++;
                        bad++;
                        $display("FAIL sb_unexpected: got transfer pc %0h, expected none", out_pc);
                    end else begin
                        e = sbq.pop_front();
                        check("sb_pc", out_pc, e.pc);
                        check("sb_instr", W'(out_instr), W'(e.ins));
                        accepted++;
                    end
                end
                prev_hold = out_valid && !out_ready && !redirect_valid;
                prev_pc   = out_pc;
                prev_ins  = out_instr;
                if (redirect_valid) mon_ep++;
            end
            rst_prev = reset;
        end
    end

    initial begin : stimulus
        int since;
        for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] = rand_word();

        // Reset, boot cycle, then one instruction per cycle.
        do_reset();
        out_ready = 1'b1;
        step(); sample();
        check("boot_valid", W'(out_valid), '0);
        check("boot_imem_addr", imem_addr, '0);
        for (int i = 0; i < 4; i++) begin
            step(); sample();
            check("seq_valid", W'(out_valid), W'(1'b1));
            check("seq_pc", out_pc, W'(4 * i));
            check("seq_instr", W'(out_instr), W'(mem[i]));
        end

        // Backpressure: output and PC hold while decode stalls.
        do_reset();
        step(); sample();
        step(); sample();
        check("first_valid", W'(out_valid), W'(1'b1));
        check("first_pc", out_pc, '0);
        for (int i = 0; i < 3; i++) begin
            step(); sample();
            check("hold_pc", out_pc, '0);
            check("hold_instr", W'(out_instr), W'(mem[0]));
            check("hold_imem_addr", imem_addr, W'(1));
        end
        step(); out_ready = 1'b1; sample();
        step(); sample();
        check("release_pc", out_pc, W'(4));

        // Redirect while a stalled output is pending.
        step(); out_ready = 1'b0; do_redirect(W'(64'h40)); sample();
        step(); redirect_valid = 1'b0; sample();
        check("redir_flush_valid", W'(out_valid), '0);
        step(); sample();
        check("redir_valid", W'(out_valid), W'(1'b1));
        check("redir_pc", out_pc, W'(64'h40));
        check("redir_instr", W'(out_instr), W'(mem[16]));

        // ebreak at word 2 halts fetch; a redirect restarts it.
        mem[2] = INSN_EBREAK;
        do_reset();
        out_ready = 1'b1;
        step(); sample();
        for (int i = 0; i < 3; i++) begin
            step(); sample();
            check("brk_pc", out_pc, W'(4 * i));
        end
        check("brk_instr", W'(out_instr), W'(INSN_EBREAK));
        check("brk_halted", W'(halted), W'(1'b1));
        step(); sample();
        check("halt_valid", W'(out_valid), '0);
        check("halt_halted", W'(halted), W'(1'b1));
        step(); sample();
        check("halt_valid2", W'(out_valid), '0);
        check("halt_imem_addr", imem_addr, W'(2));
        step(); do_redirect('0); sample();
        step(); redirect_valid = 1'b0; sample();
        check("restart_halted", W'(halted), '0);
        check("restart_valid", W'(out_valid), '0);
        step(); sample();
        check("restart_pc", out_pc, '0);
        check("restart_instr", W'(out_instr), W'(mem[0]));

        // Misaligned redirect target.
        step(); do_redirect(W'(64'h42)); sample();
        step(); redirect_valid = 1'b0; sample();
        check("mis_valid", W'(out_valid), '0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("mis_fault", W'(fault), W'(1'b1));
        check("mis_imem_addr", imem_addr, W'(64'h10));
        step(); sample();
        check("mis_fault_hold", W'(fault), W'(1'b1));
        check("mis_valid_hold", W'(out_valid), '0);
        step(); do_redirect(W'(64'h44)); sample();
        step(); redirect_valid = 1'b0; sample();
        check("mis_fault_clear", W'(fault), '0);
        step(); sample();
        check("mis_recover_pc", out_pc, W'(64'h44));
        check("mis_recover_valid", W'(out_valid), W'(1'b1));
`else
        step(); sample();
        check("mis_align_pc", out_pc, W'(64'h40));
        check("mis_align_valid", W'(out_valid), W'(1'b1));
`endif

        // PC wraps from the top of the address space to zero.
        step(); do_redirect(~64'd3); sample();
        step(); redirect_valid = 1'b0; sample();
        step(); sample();
        check("wrap_top_pc", out_pc, ~64'd3);
        check("wrap_top_instr", W'(out_instr), W'(mem[255]));
        step(); sample();
        check("wrap_zero_pc", out_pc, '0);
        check("wrap_zero_instr", W'(out_instr), W'(mem[0]));

        // Randomized traffic with sparse ebreaks, random stalls and redirects.
        for (int i = 0; i < int'(MEM_WORDS); i++)
            mem[i] = ($urandom_range(11) == 0) ? INSN_EBREAK : rand_word();
        do_reset();
        since = 0;
        for (int c = 0; c < 800; c++) begin
            step();
            redirect_valid = 1'b0;
            out_ready = ($urandom_range(9) < 7);
            since++;
            if ($urandom_range(15) == 0 || since >= 40) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                do_redirect(W'($urandom_range(255)) << 2);
`else
                do_redirect(W'($urandom_range(1023)));
`endif
                since = 0;
            end
        end
        step(); redirect_valid = 1'b0; out_ready = 1'b1;
        repeat (4) step();
        sample();
        check("enough_transfers", W'(accepted >= 100), W'(1'b1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the processor and the requesting end of the `instruction_memory` read port. It owns the program counter and drives the word-indexed memory address. It registers the returned instruction together with its PC and hands it to decode over a valid/ready handshake. It also handles redirects from branch/jump resolution and halts on `ebreak`.

## Interface
- `WORDSIZE`, 64, width of PC and memory address
- `INSTRUCTION_SIZE`, 32, instruction width
- `RESET_PC`, 0, byte address loaded into PC on reset
- `clk`  in  1  sole clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `imem_addr`  out  WORDSIZE  word index to `instruction_memory`; equals `pc >> 2`
- `imem_instruction`  in  INSTRUCTION_SIZE  combinational read data for `imem_addr`, valid in the same cycle
- `redirect_valid`  in  1  load new PC this cycle
- `redirect_pc`  in  WORDSIZE  redirect target, byte address
- `out_valid`  out  1  `out_instr`/`out_pc` hold a fetched instruction
- `out_ready`  in  1  decode accepts the current output
- `out_instr`  out  INSTRUCTION_SIZE  fetched instruction
- `out_pc`  out  WORDSIZE  byte address of `out_instr`
- `halted`  out  1  fetch stopped after `ebreak`
- `fault`  out  1  misaligned redirect trapped (only when the macro is defined)

## Operation
- FSM states: BOOT, FETCH, HALTED, FAULT.
- BOOT: entered on reset, lasts one cycle. Drives `imem_addr` for `RESET_PC`, issues nothing, then moves to FETCH.
- FETCH, issue condition `!out_valid || out_ready`:
  - `out_instr <= imem_instruction`, `out_pc <= pc`, `out_valid <= 1`, `pc <= pc + 4`.
  - If the issued instruction equals `32'h00100073` (ebreak), the state moves to HALTED.
  - The PC does not advance past the ebreak.
- FETCH, no issue (`out_valid && !out_ready`): `pc` and the output registers hold.
- Redirect handling, which has priority over issue in every state:
  - `pc <= redirect_pc`, `out_valid <= 0`; any unaccepted output is flushed.
  - The state moves to FETCH. No instruction is issued in the redirect cycle.
- HALTED: no new issue. A pending output (including the ebreak) stays until accepted, then `out_valid` drops. `halted = 1`. Only a redirect exits this state.
- Arithmetic: `pc + 4` is modulo 2^WORDSIZE, so `pc` wraps from `2^WORDSIZE-4` to 0. `imem_addr` is `{2'b00, pc[WORDSIZE-1:2]}`.
- Simultaneous redirect and `out_ready` with `out_valid=1`: decode consumes the current output in that cycle; the registers are then cleared by the redirect.

## Timing
- Reset values: `pc=RESET_PC`, `out_valid=0`, `out_instr=0`, `out_pc=0`, `halted=0`, `fault=0`, state BOOT.
- Reset asserted mid-operation: all of the above apply on the next edge, and any pending output is dropped.
- First `out_valid=1` appears on the 2nd edge after `reset` deasserts: edge 1 is BOOT→FETCH, edge 2 issues.
- Throughput is one instruction per cycle with `out_ready` held high.
- Redirect latency: target instruction appears as `out_valid` two edges after the redirect cycle.
- `out_*` are stable while `out_valid && !out_ready`.

## Configuration
- Macro: `FETCH_MISALIGN_TRAP_EN`.
- With the macro defined:
  - A redirect with `redirect_pc[1:0] != 0` enters FAULT. `fault=1`, `out_valid=0`, and `pc` holds the bad target.
  - Only an aligned redirect or `reset` exits FAULT.
- Without the macro:
  - `redirect_pc[1:0]` is ignored, so the target is forced to word alignment.
  - The FAULT state and `fault` port are absent.

## Structure
- Shared package `riscv_pkg`:
  - State enum.
  - `INSN_EBREAK = 32'h00100073`.
  - `PC_STEP = 4`.
- No sub-module. The FSM, PC register and output register stay in one module. `instruction_memory` is instantiated alongside it at processor level, not inside it.

## Test plan
- Reset held 3 cycles, then released:
  - All outputs hold their reset values during reset.
  - The first issue has `out_pc=0`, `out_instr` equal to memory word 0.
- `out_ready=1` for 4 cycles on a program of 4 non-ebreak words: `out_pc` = 0, 4, 8, 12 on consecutive cycles, with matching instructions.
- `out_ready=0` for 3 cycles after the first issue: `out_pc=0` and `out_instr` stay constant, and `imem_addr` stays 1. After release, `out_pc=4` follows.
- Redirect to 0x40 while `out_valid && !out_ready`:
  - Next cycle `out_valid=0`.
  - The cycle after, `out_pc=0x40`.
- Word 2 holds ebreak:
  - Issues at 0, 4, 8, then `halted=1` and `out_valid` drops after acceptance.
  - Redirect to 0 restarts fetch from 0.
- With `FETCH_MISALIGN_TRAP_EN`: redirect to 0x42 gives `fault=1`, `out_valid=0`. A following redirect to 0x44 clears `fault` and issues 0x44.
